// File: rtl/stopwatch_pkg.sv
// -----------------------------------------------------------------------------
// stopwatch_pkg
// Shared definitions for the stopwatch core:
//   - sw_state_e   : controller state encoding (IDLE/RUN/PAUSE/ADJUST/EXPIRED)
//   - digit_limit  : highest legal BCD value of a digit position
//   - bcd_to_seg   : BCD to active-low 7-segment {g..a} table, 10-15 blank
// No ports (package).
// -----------------------------------------------------------------------------
package stopwatch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_PAUSE   = 3'd2,
        ST_ADJUST  = 3'd3,
        ST_EXPIRED = 3'd4
    } sw_state_e;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Odd digits count tens of seconds/minutes in mm:ss mode, so they stop at 5.
    function automatic logic [3:0] digit_limit(input int index, input int mm_ss);
        if ((mm_ss != 0) && ((index % 2) == 1)) begin
            return 4'd5;
        end else begin
            return 4'd9;
        end
    endfunction

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
        case (bcd)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/stopwatch_core_if.sv
// -----------------------------------------------------------------------------
// stopwatch_core_if
// Button/switch inputs and display/status outputs of the stopwatch core.
//   master : the board/debouncer side (drives buttons, reads status/display)
//   slave  : the stopwatch core
// Signals: btn_start, btn_clear, btn_lap, adj, sel, num, dir (to core);
//          count_q, running, expired, seg, an (from core).
// -----------------------------------------------------------------------------
interface stopwatch_core_if #(
    parameter int NUM_DIGITS = 4
);
    localparam int SEL_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic                    btn_start;
    logic                    btn_clear;
    logic                    btn_lap;
    logic                    adj;
    logic [SEL_W-1:0]        sel;
    logic [3:0]              num;
    logic                    dir;
    logic [4*NUM_DIGITS-1:0] count_q;
    logic                    running;
    logic                    expired;
    logic [6:0]              seg;
    logic [NUM_DIGITS-1:0]   an;

    modport master (
        output btn_start, btn_clear, btn_lap, adj, sel, num, dir,
        input  count_q, running, expired, seg, an
    );

    modport slave (
        input  btn_start, btn_clear, btn_lap, adj, sel, num, dir,
        output count_q, running, expired, seg, an
    );

endinterface

// File: rtl/stopwatch_core_seg_scan.sv
// -----------------------------------------------------------------------------
// seg_scan
// Round-robin multiplexed 7-segment driver. Each digit is shown for
// CLK_HZ/SCAN_HZ cycles; seg and an are registered and change together.
// Ports:
//   clk, rst (sync, active-high)
//   digits [4*NUM_DIGITS-1:0] : BCD digits, digit 0 in [3:0]
//   seg    [6:0]              : active-low segments {g..a}
//   an     [NUM_DIGITS-1:0]   : active-low anodes, an[0] rightmost
// -----------------------------------------------------------------------------
module seg_scan
    import stopwatch_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int CLK_HZ     = 100000000,
    parameter int SCAN_HZ    = 1000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] digits,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an
);
    localparam int SCAN_TERM = CLK_HZ / SCAN_HZ - 1;
    localparam int DIV_W     = (SCAN_TERM > 0) ? $clog2(SCAN_TERM + 1) : 1;
    localparam int IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [DIV_W-1:0]      div_q, div_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [6:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;

    // Dwell divider, digit index advance and decode of the digit being shown
    always_comb begin
        div_d = div_q;
        idx_d = idx_q;
        if (div_q == DIV_W'(SCAN_TERM)) begin
            div_d = {DIV_W{1'b0}};
            if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
                idx_d = {IDX_W{1'b0}};
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end else begin
            div_d = div_q + DIV_W'(1);
        end
        seg_d = bcd_to_seg(digits[int'(idx_q) * 4 +: 4]);
        an_d  = ~({{(NUM_DIGITS - 1){1'b0}}, 1'b1} << idx_q);
    end

    // Scan state and registered display outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= {DIV_W{1'b0}};
            idx_q <= {IDX_W{1'b0}};
            seg_q <= SEG_BLANK;
            an_q  <= {NUM_DIGITS{1'b1}};
        end else begin
            div_q <= div_d;
            idx_q <= idx_d;
            seg_q <= seg_d;
            an_q  <= an_d;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;

endmodule

// File: rtl/stopwatch_core.sv
// -----------------------------------------------------------------------------
// stopwatch_core
// BCD stopwatch / countdown engine with run/pause, clear, per-digit adjust
// and an integrated multiplexed 7-segment driver.
// Ports:
//   clk, rst (sync, active-high)
//   bus (stopwatch_core_if.slave):
//     btn_start/btn_clear/btn_lap : single-cycle pulses
//     adj, sel, num               : adjust level, digit select, BCD value
//     dir                         : 0 up, 1 down (sampled per tick)
//     count_q, running, expired   : live count and status
//     seg, an                     : active-low display drive
// Optional feature macro: LAP_EN (lap register freezes the display while the
// count continues; without it btn_lap is ignored).
// -----------------------------------------------------------------------------
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ     = 100000000,
    parameter int TICK_HZ    = 1,
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_HZ    = 1000,
    parameter int MM_SS      = 1
) (
    input logic             clk,
    input logic             rst,
    stopwatch_core_if.slave bus
);
    localparam int CW       = 4 * NUM_DIGITS;
    localparam int PRE_TERM = CLK_HZ / TICK_HZ - 1;
    localparam int PRE_W    = (PRE_TERM > 0) ? $clog2(PRE_TERM + 1) : 1;

    sw_state_e        state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d, cnt_inc_s, cnt_dec_s, cnt_adj_s, disp_s;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic             running_q, running_d, expired_q, expired_d;
    logic             tick_s, inc_carry_s, dec_borrow_s;
    logic [3:0]       lim_s;

    // Candidate counts: ripple increment, ripple decrement, clamped adjust write
    always_comb begin
        cnt_inc_s    = cnt_q;
        cnt_dec_s    = cnt_q;
        cnt_adj_s    = cnt_q;
        inc_carry_s  = 1'b1;
        dec_borrow_s = 1'b1;
        lim_s        = 4'd9;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            lim_s = digit_limit(i, MM_SS);
            if (inc_carry_s) begin
                if (cnt_q[4*i +: 4] >= lim_s) begin
                    cnt_inc_s[4*i +: 4] = 4'd0;
                end else begin
                    cnt_inc_s[4*i +: 4] = cnt_q[4*i +: 4] + 4'd1;
                    inc_carry_s         = 1'b0;
                end
            end else begin
                cnt_inc_s[4*i +: 4] = cnt_q[4*i +: 4];
            end
            if (dec_borrow_s) begin
                if (cnt_q[4*i +: 4] == 4'd0) begin
                    cnt_dec_s[4*i +: 4] = lim_s;
                end else begin
                    cnt_dec_s[4*i +: 4] = cnt_q[4*i +: 4] - 4'd1;
                    dec_borrow_s        = 1'b0;
                end
            end else begin
                cnt_dec_s[4*i +: 4] = cnt_q[4*i +: 4];
            end
            // Out-of-range sel matches no digit, so nothing is written.
            if (int'(bus.sel) == i) begin
                cnt_adj_s[4*i +: 4] = (bus.num > lim_s) ? lim_s : bus.num;
            end else begin
                cnt_adj_s[4*i +: 4] = cnt_q[4*i +: 4];
            end
        end
    end

    // Controller next state: clear > adjust > start; ticks only while running
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pre_d   = pre_q;
        tick_s  = (state_q == ST_RUN) && (pre_q == PRE_W'(PRE_TERM));
        if (bus.btn_clear) begin
            cnt_d   = {CW{1'b0}};
            pre_d   = {PRE_W{1'b0}};
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.btn_start) begin
                        // Counting down from zero has nothing left to count.
                        state_d = (bus.dir && (cnt_q == {CW{1'b0}})) ? ST_EXPIRED : ST_RUN;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    pre_d = tick_s ? {PRE_W{1'b0}} : (pre_q + PRE_W'(1));
                    if (tick_s) begin
                        cnt_d = bus.dir ? cnt_dec_s : cnt_inc_s;
                    end else begin
                        cnt_d = cnt_q;
                    end
                    if (bus.adj) begin
                        state_d = ST_ADJUST;
                    end else if (bus.btn_start) begin
                        state_d = ST_PAUSE;
                    end else if (tick_s && bus.dir && (cnt_dec_s == {CW{1'b0}})) begin
                        state_d = ST_EXPIRED;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_PAUSE: begin
                    if (bus.adj) begin
                        state_d = ST_ADJUST;
                    end else if (bus.btn_start) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_PAUSE;
                    end
                end
                ST_ADJUST: begin
                    if (bus.adj) begin
                        cnt_d = cnt_adj_s;
                    end else begin
                        state_d = ST_PAUSE;
                    end
                end
                ST_EXPIRED: begin
                    if (bus.btn_start) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_EXPIRED;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
        running_d = (state_d == ST_RUN);
        expired_d = (state_d == ST_EXPIRED);
    end

    // Controller state, count, prescaler and registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= {CW{1'b0}};
            pre_q     <= {PRE_W{1'b0}};
            running_q <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pre_q     <= pre_d;
            running_q <= running_d;
            expired_q <= expired_d;
        end
    end

`ifdef LAP_EN
    logic [CW-1:0] lap_q, lap_d;
    logic          lap_hold_q, lap_hold_d;

    // Lap capture in RUN, release on a second press, dropped by clear
    always_comb begin
        lap_d      = lap_q;
        lap_hold_d = lap_hold_q;
        if (bus.btn_clear) begin
            lap_hold_d = 1'b0;
        end else if (bus.btn_lap && lap_hold_q) begin
            lap_hold_d = 1'b0;
        end else if (bus.btn_lap && (state_q == ST_RUN)) begin
            lap_d      = cnt_q;
            lap_hold_d = 1'b1;
        end else begin
            lap_hold_d = lap_hold_q;
        end
    end

    // Lap register and hold flag
    always_ff @(posedge clk) begin
        if (rst) begin
            lap_q      <= {CW{1'b0}};
            lap_hold_q <= 1'b0;
        end else begin
            lap_q      <= lap_d;
            lap_hold_q <= lap_hold_d;
        end
    end

    assign disp_s = lap_hold_q ? lap_q : cnt_q;
`else
    logic unused_lap_s;
    assign unused_lap_s = bus.btn_lap;
    assign disp_s       = cnt_q;
`endif

    assign bus.count_q = cnt_q;
    assign bus.running = running_q;
    assign bus.expired = expired_q;

    seg_scan #(
        .NUM_DIGITS (NUM_DIGITS),
        .CLK_HZ     (CLK_HZ),
        .SCAN_HZ    (SCAN_HZ)
    ) u_seg_scan (
        .clk    (clk),
        .rst    (rst),
        .digits (disp_s),
        .seg    (bus.seg),
        .an     (bus.an)
    );

endmodule

// File: tb/tb_stopwatch_core.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_core
// Directed, self-checking bench for stopwatch_core with CLK_HZ=10, TICK_HZ=1,
// SCAN_HZ=5, NUM_DIGITS=4, MM_SS=1 (10 cycles per tick, 2 cycles per digit).
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_stopwatch_core;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    stopwatch_core_if #(.NUM_DIGITS(4)) bus ();

    stopwatch_core #(
        .CLK_HZ     (10),
        .TICK_HZ    (1),
        .NUM_DIGITS (4),
        .SCAN_HZ    (5),
        .MM_SS      (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference segment table written active-high, inverted for the board.
    function automatic logic [6:0] ref_seg(input logic [3:0] d);
        logic [6:0] on;
        case (d)
            4'd0: on = 7'h3F;
            4'd1: on = 7'h06;
            4'd2: on = 7'h5B;
            4'd3: on = 7'h4F;
            4'd4: on = 7'h66;
            4'd5: on = 7'h6D;
            4'd6: on = 7'h7D;
            4'd7: on = 7'h07;
            4'd8: on = 7'h7F;
            4'd9: on = 7'h6F;
            default: on = 7'h00;
        endcase
        return ~on;
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        bus.btn_start = 1'b1;
        cyc(1);
        bus.btn_start = 1'b0;
    endtask

    task automatic pulse_clear();
        bus.btn_clear = 1'b1;
        cyc(1);
        bus.btn_clear = 1'b0;
    endtask

    // Watch one full scan round and check every sample against val.
    task automatic chk_disp(input string tag, input logic [15:0] val);
        logic [3:0] seen;
        seen = 4'h0;
        for (int k = 0; k < 8; k++) begin
            cyc(1);
            chk({tag, "_an_onehot"}, 32'($countones(~bus.an)), 32'd1);
            for (int d = 0; d < 4; d++) begin
                if (bus.an[d] == 1'b0) begin
                    seen[d] = 1'b1;
                    chk({tag, "_seg"}, 32'(bus.seg), 32'(ref_seg(val[4*d +: 4])));
                end
            end
        end
        chk({tag, "_all_digits"}, 32'(seen), 32'h0000000F);
    endtask

    initial begin
        bus.btn_start = 1'b0;
        bus.btn_clear = 1'b0;
        bus.btn_lap   = 1'b0;
        bus.adj       = 1'b0;
        bus.sel       = 2'd0;
        bus.num       = 4'd0;
        bus.dir       = 1'b0;

        // Reset
        cyc(3);
        chk("rst_count", 32'(bus.count_q), 32'h0000);
        chk("rst_running", 32'(bus.running), 32'h0);
        chk("rst_expired", 32'(bus.expired), 32'h0);
        chk("rst_an", 32'(bus.an), 32'hF);
        chk("rst_seg", 32'(bus.seg), 32'h7F);
        rst = 1'b0;

        // 60 ticks up: 00:59 rolls into 01:00
        pulse_start();
        cyc(600);
        chk("up_600_count", 32'(bus.count_q), 32'h0100);
        chk("up_600_running", 32'(bus.running), 32'h1);

        // Pause keeps count and prescaler phase
        pulse_clear();
        chk("clear_count", 32'(bus.count_q), 32'h0000);
        chk("clear_running", 32'(bus.running), 32'h0);
        pulse_start();
        cyc(50);
        chk("run_to_5", 32'(bus.count_q), 32'h0005);
        pulse_start();
        cyc(50);
        chk("pause_hold", 32'(bus.count_q), 32'h0005);
        chk("pause_running", 32'(bus.running), 32'h0);
        pulse_start();
        cyc(8);
        chk("resume_pre_tick", 32'(bus.count_q), 32'h0005);
        cyc(1);
        chk("resume_tick", 32'(bus.count_q), 32'h0006);

        // Adjust with clamping
        bus.adj = 1'b1;
        bus.sel = 2'd0;
        bus.num = 4'd0;
        cyc(3);
        chk("adj_d0", 32'(bus.count_q), 32'h0000);
        bus.sel = 2'd1;
        bus.num = 4'd9;
        cyc(2);
        chk("adj_d1_clamp", 32'(bus.count_q), 32'h0050);
        bus.sel = 2'd3;
        bus.num = 4'd2;
        cyc(2);
        chk("adj_d3", 32'(bus.count_q), 32'h2050);
        bus.sel = 2'd2;
        bus.num = 4'd12;
        cyc(2);
        chk("adj_d2_clamp", 32'(bus.count_q), 32'h2950);
        bus.adj = 1'b0;
        cyc(21);
        chk("adj_exit_hold", 32'(bus.count_q), 32'h2950);
        chk("adj_exit_running", 32'(bus.running), 32'h0);
        chk_disp("disp_2950", 16'h2950);

        // Countdown from zero expires immediately
        pulse_clear();
        bus.dir = 1'b1;
        pulse_start();
        chk("zero_down_expired", 32'(bus.expired), 32'h1);
        chk("zero_down_running", 32'(bus.running), 32'h0);
        pulse_start();
        chk("expired_start_idle", 32'(bus.expired), 32'h0);
        chk("expired_start_count", 32'(bus.count_q), 32'h0000);

        // Countdown 0002 -> expire
        bus.dir = 1'b0;
        pulse_start();
        bus.adj = 1'b1;
        bus.sel = 2'd0;
        bus.num = 4'd2;
        cyc(3);
        bus.adj = 1'b0;
        cyc(1);
        chk("down_setup", 32'(bus.count_q), 32'h0002);
        bus.dir = 1'b1;
        pulse_start();
        cyc(10);
        chk("down_one_tick", 32'(bus.count_q), 32'h0001);
        cyc(10);
        chk("down_zero_count", 32'(bus.count_q), 32'h0000);
        chk("down_expired", 32'(bus.expired), 32'h1);
        chk("down_exp_running", 32'(bus.running), 32'h0);
        pulse_clear();
        chk("exp_clear_expired", 32'(bus.expired), 32'h0);
        chk("exp_clear_count", 32'(bus.count_q), 32'h0000);

        // Borrow through the mod-6 digit: 01:00 -> 00:59 -> 00:58
        bus.dir = 1'b0;
        pulse_start();
        bus.adj = 1'b1;
        bus.sel = 2'd2;
        bus.num = 4'd1;
        cyc(3);
        bus.adj = 1'b0;
        cyc(1);
        chk("borrow_setup", 32'(bus.count_q), 32'h0100);
        bus.dir = 1'b1;
        pulse_start();
        cyc(9);
        chk("borrow_0059", 32'(bus.count_q), 32'h0059);
        cyc(10);
        chk("borrow_0058", 32'(bus.count_q), 32'h0058);

        // Full up wrap 59:59 -> 00:00 keeps running
        pulse_clear();
        bus.dir = 1'b0;
        pulse_start();
        bus.adj = 1'b1;
        bus.sel = 2'd0;
        bus.num = 4'd9;
        cyc(2);
        bus.sel = 2'd1;
        bus.num = 4'd5;
        cyc(1);
        bus.sel = 2'd2;
        bus.num = 4'd9;
        cyc(1);
        bus.sel = 2'd3;
        bus.num = 4'd5;
        cyc(1);
        bus.adj = 1'b0;
        cyc(1);
        chk("wrap_setup", 32'(bus.count_q), 32'h5959);
        pulse_start();
        cyc(9);
        chk("wrap_count", 32'(bus.count_q), 32'h0000);
        chk("wrap_running", 32'(bus.running), 32'h1);
        chk("wrap_not_expired", 32'(bus.expired), 32'h0);

        // Same-cycle clear and start: clear wins
        pulse_clear();
        pulse_start();
        cyc(25);
        chk("cs_pre_count", 32'(bus.count_q), 32'h0002);
        bus.btn_clear = 1'b1;
        bus.btn_start = 1'b1;
        cyc(1);
        bus.btn_clear = 1'b0;
        bus.btn_start = 1'b0;
        chk("cs_count", 32'(bus.count_q), 32'h0000);
        chk("cs_running", 32'(bus.running), 32'h0);
        cyc(20);
        chk("cs_idle_hold", 32'(bus.count_q), 32'h0000);

        // Lap press
        pulse_clear();
        pulse_start();
        cyc(30);
        chk("lap_pre_count", 32'(bus.count_q), 32'h0003);
        bus.btn_lap = 1'b1;
        cyc(1);
        bus.btn_lap = 1'b0;
        cyc(30);
        chk("lap_live_count", 32'(bus.count_q), 32'h0006);
`ifdef LAP_EN
        chk_disp("lap_frozen", 16'h0003);
        bus.btn_lap = 1'b1;
        cyc(1);
        bus.btn_lap = 1'b0;
        cyc(2);
        chk("lap_release_count", 32'(bus.count_q), 32'h0007);
        chk_disp("lap_released", 16'h0007);
`else
        chk_disp("lap_ignored", 16'h0006);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
